// File: rtl/tl_pkg.sv
// tl_pkg: lamp and state encodings shared by the N-phase traffic controller
package tl_pkg;
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;
   typedef enum logic [1:0] {ST_GREEN = 2'd0, ST_YELLOW = 2'd1, ST_ALLRED = 2'd2} tl_state_e;
   function automatic int ph_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/traffic_light_ctrl_n_if.sv
// traffic_light_ctrl_n_if: sensor/preempt inputs and lamp/status outputs of the controller
interface traffic_light_ctrl_n_if import tl_pkg::*; #(
   parameter int NUM_PHASES = 4,
   parameter int CNT_W      = 4,
   localparam int PH_W      = ph_w(NUM_PHASES)
);
   logic [NUM_PHASES-1:0]   demand;
   logic                    preempt_req;
   logic [PH_W-1:0]         preempt_phase;
   logic [3*NUM_PHASES-1:0] lights;
   logic [PH_W-1:0]         active_phase;
   logic [1:0]              state_o;
   logic [CNT_W-1:0]        count;
   logic                    preempt_active;
   modport master (output demand, preempt_req, preempt_phase,
                   input lights, active_phase, state_o, count, preempt_active);
   modport slave (input demand, preempt_req, preempt_phase,
                  output lights, active_phase, state_o, count, preempt_active);
endinterface

// File: rtl/tl_phase_arbiter.sv
// tl_phase_arbiter: round-robin pick of the next waiting phase after active_phase
module tl_phase_arbiter import tl_pkg::*; #(
   parameter int NUM_PHASES = 4,
   localparam int PH_W      = ph_w(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] dem_q,
   input  logic [PH_W-1:0]       active_phase,
   output logic [PH_W-1:0]       pick,
   output logic                  pick_valid
);
   logic [PH_W-1:0] idx;
   // Walk farthest-first so the nearest requester after active_phase wins last
   always_comb begin
      pick = active_phase;
      pick_valid = 1'b0;
      idx = '0;
      for (int k = NUM_PHASES - 1; k > 0; k--) begin
         idx = PH_W'((int'(active_phase) + k) % NUM_PHASES);
         if (dem_q[idx]) begin
            pick = idx;
            pick_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: N-phase green/yellow/all-red controller with demand latching and preempt
module traffic_light_ctrl_n import tl_pkg::*; #(
   parameter int NUM_PHASES  = 4,
   parameter int GREEN_TIME  = 7,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1,
   parameter int CNT_W       = 4
) (
   input logic clk,
   input logic rst,
   traffic_light_ctrl_n_if.slave bus
);
   localparam int PH_W = ph_w(NUM_PHASES);
   tl_state_e state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [PH_W-1:0] active, active_n, target, target_n, pick;
   logic [NUM_PHASES-1:0] dem_q, dem_n;
   logic [3*NUM_PHASES-1:0] lights, lights_n;
   logic pa, pa_n, pick_valid, pv, load_pre;

   function automatic logic [3*NUM_PHASES-1:0] decode(input tl_state_e s, input logic [PH_W-1:0] a);
      decode = '0;
      for (int i = 0; i < NUM_PHASES; i++)
         decode[3*i +: 3] = (s != ST_ALLRED && a == PH_W'(i)) ? ((s == ST_GREEN) ? GREEN : YELLOW) : RED;
   endfunction

   assign pv = bus.preempt_req && (int'(bus.preempt_phase) < NUM_PHASES);

   tl_phase_arbiter #(.NUM_PHASES(NUM_PHASES)) u_arb (
      .dem_q(dem_q), .active_phase(active), .pick(pick), .pick_valid(pick_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_GREEN;
         count  <= '0;
         active <= '0;
         target <= '0;
         dem_q  <= '0;
         pa     <= 1'b0;
         lights <= decode(ST_GREEN, '0);
      end else begin
         state  <= state_n;
         count  <= count_n;
         active <= active_n;
         target <= target_n;
         dem_q  <= dem_n;
         pa     <= pa_n;
         lights <= lights_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count + 1'b1;
      active_n = active;
      target_n = target;
      load_pre = 1'b0;
      unique case (state)
         ST_GREEN:
            if (pv && bus.preempt_phase != active) begin
               state_n = ST_YELLOW;
               count_n = '0;
               target_n = bus.preempt_phase;
               load_pre = 1'b1;
            end else if (count == CNT_W'(GREEN_TIME)) begin
               count_n = count;
               if (pick_valid && !pv) begin
                  state_n = ST_YELLOW;
                  count_n = '0;
                  target_n = pick;
               end
            end
         ST_YELLOW: begin
            if (pv) begin
               target_n = bus.preempt_phase;
               load_pre = 1'b1;
            end
            if (count == CNT_W'(YELLOW_TIME)) begin
               state_n = ST_ALLRED;
               count_n = '0;
            end
         end
         ST_ALLRED: begin
            if (pv) begin
               target_n = bus.preempt_phase;
               load_pre = 1'b1;
            end
            if (count == CNT_W'(ALLRED_TIME)) begin
               state_n = ST_GREEN;
               count_n = '0;
               active_n = target_n;
            end
         end
         default: begin
            state_n = ST_GREEN;
            count_n = '0;
         end
      endcase
   end

   // Demand of the green phase is dropped both while it is green and on the cycle it turns green
   always_comb begin
      pa_n = load_pre ? 1'b1 : (state == ST_GREEN && !bus.preempt_req) ? 1'b0 : pa;
      dem_n = (dem_q | bus.demand)
            & ~((state == ST_GREEN ? NUM_PHASES'(1) << active : '0)
              | (state_n == ST_GREEN ? NUM_PHASES'(1) << active_n : '0));
      lights_n = decode(state_n, active_n);
   end

   assign bus.lights = lights;
   assign bus.active_phase = active;
   assign bus.state_o = state;
   assign bus.count = count;
   assign bus.preempt_active = pa;
endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n: directed checks of the 4-phase and 3-phase controller
module tb_traffic_light_ctrl_n;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl_n_if #(.NUM_PHASES(4), .CNT_W(4)) b4 ();
   traffic_light_ctrl_n_if #(.NUM_PHASES(3), .CNT_W(4)) b3 ();

   traffic_light_ctrl_n #(.NUM_PHASES(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
   traffic_light_ctrl_n #(.NUM_PHASES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      b4.demand = '0; b4.preempt_req = 1'b0; b4.preempt_phase = '0;
      b3.demand = '0; b3.preempt_req = 1'b0; b3.preempt_phase = '0;
      // all demand held high: 13-cycle service per phase
      b4.demand = 4'b1111;
      do_reset;
      chk("rst_state", b4.state_o, 0);
      chk("rst_active", b4.active_phase, 0);
      chk("rst_count", b4.count, 0);
      chk("rst_lights", b4.lights, 12'h921);
      chk("rst_pa", b4.preempt_active, 0);
      step(7);
      chk("rr_g7_count", b4.count, 7);
      chk("rr_g7_state", b4.state_o, 0);
      step(1);
      chk("rr_y_state", b4.state_o, 1);
      chk("rr_y_lights", b4.lights, 12'h922);
      step(3);
      chk("rr_ar_state", b4.state_o, 2);
      chk("rr_ar_lights", b4.lights, 12'h924);
      step(2);
      chk("rr_p1_state", b4.state_o, 0);
      chk("rr_p1_active", b4.active_phase, 1);
      chk("rr_p1_lights", b4.lights, 12'h90C);
      step(13);
      chk("rr_p2_active", b4.active_phase, 2);
      step(13);
      chk("rr_p3_active", b4.active_phase, 3);
      step(13);
      chk("rr_p0_active", b4.active_phase, 0);
      chk("rr_p0_count", b4.count, 0);
      // no demand: rest in phase 0 green with saturated count
      b4.demand = '0;
      do_reset;
      step(20);
      chk("idle_state", b4.state_o, 0);
      chk("idle_count", b4.count, 7);
      chk("idle_lights", b4.lights, 12'h921);
      // single demand pulse for phase 2 skips phases 1 and 3
      do_reset;
      step(3);
      b4.demand = 4'b0100;
      step(1);
      b4.demand = '0;
      chk("d2_latched", u4.dem_q, 4'b0100);
      step(3);
      chk("d2_g7", b4.count, 7);
      step(1);
      chk("d2_y", b4.state_o, 1);
      step(5);
      chk("d2_active", b4.active_phase, 2);
      chk("d2_lights", b4.lights, 12'h864);
      chk("d2_dem_clr", u4.dem_q, 0);
      step(12);
      chk("d2_rest_active", b4.active_phase, 2);
      chk("d2_rest_count", b4.count, 7);
      // preempt to phase 3 from phase 0 green at count 2
      do_reset;
      step(2);
      b4.preempt_req = 1'b1;
      b4.preempt_phase = 2'd3;
      step(1);
      chk("pre_y_state", b4.state_o, 1);
      chk("pre_y_count", b4.count, 0);
      chk("pre_y_pa", b4.preempt_active, 1);
      step(3);
      chk("pre_ar_state", b4.state_o, 2);
      step(2);
      chk("pre_g_active", b4.active_phase, 3);
      chk("pre_g_lights", b4.lights, 12'h324);
      chk("pre_g_pa", b4.preempt_active, 1);
      step(4);
      chk("pre_hold_count", b4.count, 4);
      chk("pre_hold_state", b4.state_o, 0);
      b4.preempt_req = 1'b0;
      b4.demand = 4'b0001;
      step(1);
      b4.demand = '0;
      chk("rel_count", b4.count, 5);
      chk("rel_pa", b4.preempt_active, 0);
      step(2);
      chk("rel_g7", b4.count, 7);
      step(1);
      chk("rel_y", b4.state_o, 1);
      step(5);
      chk("rel_active", b4.active_phase, 0);
      // reset mid-yellow of phase 1
      b4.demand = 4'b1111;
      do_reset;
      step(22);
      chk("mr_y_state", b4.state_o, 1);
      chk("mr_y_count", b4.count, 1);
      chk("mr_y_active", b4.active_phase, 1);
      b4.demand = '0;
      do_reset;
      chk("mr_state", b4.state_o, 0);
      chk("mr_active", b4.active_phase, 0);
      chk("mr_count", b4.count, 0);
      chk("mr_lights", b4.lights, 12'h921);
      chk("mr_dem", u4.dem_q, 0);
      // 3-phase: out-of-range preempt phase is ignored
      do_reset;
      b3.demand = 3'b010;
      b3.preempt_req = 1'b1;
      b3.preempt_phase = 2'd3;
      step(1);
      b3.demand = '0;
      chk("n3_count", b3.count, 1);
      chk("n3_pa", b3.preempt_active, 0);
      step(6);
      chk("n3_g7", b3.count, 7);
      step(1);
      chk("n3_y", b3.state_o, 1);
      chk("n3_y_pa", b3.preempt_active, 0);
      step(5);
      chk("n3_active", b3.active_phase, 1);
      chk("n3_lights", b3.lights, 9'h10C);
      chk("n3_pa_end", b3.preempt_active, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/traffic_light_ctrl_n.md
Name: traffic_light_ctrl_n

Overview:
Parametrised N-phase successor to the fixed 4-way controller. Serves one phase at a time through GREEN, YELLOW and ALL-RED clearance. Phases are selected round-robin from latched vehicle demand, and the controller rests in green when no other phase is waiting. An emergency preempt input can cut the current green short and force a chosen phase. Sits between sensor/preempt inputs and the lamp drivers.

Parameters:
NUM_PHASES, 4, number of signal phases (2..16)
GREEN_TIME, 7, green lasts GREEN_TIME+1 cycles (count 0..GREEN_TIME)
YELLOW_TIME, 2, yellow lasts YELLOW_TIME+1 cycles
ALLRED_TIME, 1, all-red clearance lasts ALLRED_TIME+1 cycles
CNT_W, 4, counter width; must hold max(GREEN_TIME, YELLOW_TIME, ALLRED_TIME)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
demand  in  NUM_PHASES  per-phase request; a single-cycle pulse is sufficient (latched)
preempt_req  in  1  emergency preempt, level-sensitive
preempt_phase  in  PH_W  target phase for preempt; PH_W = max(1,$clog2(NUM_PHASES))
lights  out  3*NUM_PHASES  phase i lamp at [3i+2:3i]; RED=100, YELLOW=010, GREEN=001
active_phase  out  PH_W  phase currently or last served
state_o  out  2  GREEN=0, YELLOW=1, ALLRED=2
count  out  CNT_W  cycles elapsed in current state
preempt_active  out  1  high while the controller is serving or moving to a preempt phase

Behaviour:
- Reset (synchronous, takes effect mid-operation too): state=GREEN, active_phase=0, count=0, demand latches cleared, target=0, preempt_active=0. lights = phase 0 GREEN, all others RED, on the cycle after the reset edge.
- Demand latch: dem_q[i] is set by demand[i]=1. It is cleared on the cycle phase i enters GREEN. Demand for the currently green phase is ignored (not latched).
- Next-phase pick (combinational): first i with dem_q[i]=1, searching from active_phase+1 upward with wrap-around and excluding active_phase. "none" if no such i.
- GREEN:
  - If a valid preempt is pending for another phase: go to YELLOW next cycle, count=0, target=preempt_phase.
  - If preempt_phase == active_phase: hold GREEN with count saturating at GREEN_TIME.
  - Otherwise, when count==GREEN_TIME and the pick is valid: go to YELLOW, count=0, target=pick.
  - When count==GREEN_TIME and the pick is none: rest in GREEN, count holds at GREEN_TIME.
  - Otherwise count increments.
- YELLOW: at count==YELLOW_TIME go to ALLRED, count=0; otherwise count increments.
- ALLRED: at count==ALLRED_TIME go to GREEN, active_phase=target, count=0; otherwise count increments.
- Preempt override: a valid preempt asserted during YELLOW or ALLRED overwrites target with preempt_phase. Clearance timing is never shortened.
- A preempt is valid only when preempt_req=1 and preempt_phase < NUM_PHASES. An invalid preempt_phase is ignored entirely.
- preempt_active is set when target is loaded from preempt. It clears the first GREEN cycle with preempt_req=0.
- Preempt release: after preempt_req drops, the preempted green continues counting from its current value and exits normally.
- lights is a registered decode of state and active_phase:
  - Exactly one phase is non-RED in GREEN and YELLOW.
  - All phases are RED in ALLRED.
  - No phase ever goes GREEN directly to RED or GREEN directly to GREEN.
- Counter arithmetic is unsigned CNT_W-bit and never wraps: every path either resets count or saturates it.

Decomposition:
- Shared package tl_pkg: light encodings RED/YELLOW/GREEN (3-bit), state encoding (2-bit), localparam helper for PH_W.
- One sub-module, tl_phase_arbiter: a combinational round-robin demand picker with inputs dem_q and active_phase, and outputs pick and pick_valid.
- FSM, counter, demand latches and lamp decode stay in traffic_light_ctrl_n.

Test Plan:
- All demand held high, defaults: phase 0 green for 8 cycles, yellow 3, all-red 2, then phase 1 green. Serve order 0,1,2,3,0; full rotation is 52 cycles.
- No demand after reset: phase 0 stays GREEN indefinitely, count saturates at 7, state_o=0, no other lamp changes.
- Single demand[2] pulse at cycle 3: phase 0 exits at count 7, then yellow 3 and all-red 2, then phase 2 GREEN. dem_q[2] clears that cycle and phases 1 and 3 are skipped.
- preempt_req=1, preempt_phase=3 at phase 0 green count=2: YELLOW next cycle, then ALLRED, then phase 3 GREEN with preempt_active=1, held while req is high. Release: count runs to 7 then normal exit.
- rst asserted during YELLOW of phase 1 at count=1: next cycle state=GREEN, active_phase=0, count=0, lights phase 0 GREEN, all demand latches cleared.
- NUM_PHASES=3, preempt_phase=3 with preempt_req=1: ignored, normal sequencing continues, preempt_active stays 0.
